// File: rtl/hello_world_nios2e_cpu_debug_monmem.sv
// Debug monitor memory controller (sysclk domain).
// Runs debugger word reads and writes into a small monitor RAM, using the
// take_*_ocimem strobes and jdo. A single-entry pending slot absorbs one
// command that arrives while the controller is busy. The same RAM is also
// reachable from the CPU through an Avalon-MM slave port. In the same cycle
// the debugger always wins over the CPU.
module hello_world_nios2e_cpu_debug_monmem #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [ADDR_W-1:0] MonAReg,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_DRD = 3'd1, S_DCAP = 3'd2, S_DWR = 3'd3, S_CRD = 3'd4
  } state_t;
  typedef enum logic [1:0] {K_A = 2'd0, K_B = 2'd1, K_NA = 2'd2} kind_t;

  state_t            state_r, state_s;
  logic              pend_v_r, pend_v_s;
  kind_t             pend_kind_r, pend_kind_s;
  logic [37:0]       pend_jdo_r, pend_jdo_s;
  logic [31:0]       wr_data_r, ram_q_r, readdata_r, mon_d_r;
  logic [ADDR_W-1:0] mon_a_r;
  logic              rd_done_r, ready_r, error_r, ready_s;
  logic [31:0]       mem [DEPTH];

  logic              strobe_any_s, strobe_multi_s, idle_s, store_s, drop_s;
  kind_t             strobe_kind_s, exec_kind_s;
  logic              exec_v_s;
  logic [37:0]       exec_jdo_s;
  logic              cpu_rd_go_s, cpu_wr_go_s, err_set_s, err_clr_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s, mem_raddr_s;
  logic [31:0]       mem_wdata_s;
  logic [3:0]        mem_be_s;
  logic              unused_jdo_s;

  assign readdata      = readdata_r;
  assign MonAReg       = mon_a_r;
  assign MonDReg       = mon_d_r;
  assign monitor_ready = ready_r;
  assign monitor_error = error_r;
  assign unused_jdo_s  = ^{exec_jdo_s[37:36], exec_jdo_s[2:0]};

  // Strobe decode, selection of the command to run, pending-slot update and CPU stall.
  always_comb begin
    strobe_any_s   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    strobe_multi_s = (take_action_ocimem_a & take_action_ocimem_b) |
                     (take_action_ocimem_a & take_no_action_ocimem_a) |
                     (take_action_ocimem_b & take_no_action_ocimem_a);
    if (take_action_ocimem_a)      strobe_kind_s = K_A;
    else if (take_action_ocimem_b) strobe_kind_s = K_B;
    else                           strobe_kind_s = K_NA;
    idle_s      = (state_r == S_IDLE);
    exec_v_s    = 1'b0;
    exec_kind_s = K_A;
    exec_jdo_s  = jdo;
    // A pending command always runs before a strobe arriving in the same cycle.
    if (idle_s && pend_v_r) begin
      exec_v_s    = 1'b1;
      exec_kind_s = pend_kind_r;
      exec_jdo_s  = pend_jdo_r;
    end else if (idle_s && strobe_any_s) begin
      exec_v_s    = 1'b1;
      exec_kind_s = strobe_kind_s;
    end else begin
      exec_v_s    = 1'b0;
    end
    store_s     = strobe_any_s && (!idle_s || pend_v_r);
    drop_s      = store_s && pend_v_r && !idle_s;
    pend_v_s    = pend_v_r;
    pend_kind_s = pend_kind_r;
    pend_jdo_s  = pend_jdo_r;
    if (store_s && !drop_s) begin
      pend_v_s    = 1'b1;
      pend_kind_s = strobe_kind_s;
      pend_jdo_s  = jdo;
    end else if (idle_s && pend_v_r) begin
      pend_v_s    = 1'b0;
    end else begin
      pend_v_s    = pend_v_r;
    end
    cpu_rd_go_s = idle_s && !strobe_any_s && !pend_v_r && read && !rd_done_r;
    cpu_wr_go_s = idle_s && !strobe_any_s && !pend_v_r && write && !read;
    err_set_s   = strobe_multi_s || drop_s;
    err_clr_s   = exec_v_s && (exec_kind_s == K_A) && exec_jdo_s[35];
    // A served read sees waitrequest low for exactly one cycle (rd_done_r).
    waitrequest = !idle_s || strobe_any_s || pend_v_r || (read && !rd_done_r);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_r <= S_IDLE;
    else          state_r <= state_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (exec_v_s) begin
          case (exec_kind_s)
            K_A:     state_s = exec_jdo_s[34] ? S_DRD : S_IDLE;
            K_B:     state_s = S_DWR;
            K_NA:    state_s = S_DRD;
            default: state_s = S_IDLE;
          endcase
        end else if (cpu_rd_go_s) begin
          state_s = S_CRD;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DRD:   state_s = S_DCAP;
      S_DCAP:  state_s = S_IDLE;
      S_DWR:   state_s = S_IDLE;
      S_CRD:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // FSM outputs: RAM port controls and next monitor_ready.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = mon_a_r;
    mem_wdata_s = wr_data_r;
    mem_be_s    = 4'hF;
    if (state_r == S_DWR) begin
      mem_we_s    = reset_n;
    end else if (cpu_wr_go_s) begin
      mem_we_s    = reset_n;
      mem_waddr_s = address;
      mem_wdata_s = writedata;
      mem_be_s    = byteenable;
    end else begin
      mem_we_s    = 1'b0;
    end
    // The CPU read is launched in its accept cycle, so data sits in ram_q_r during CRD.
    mem_raddr_s = cpu_rd_go_s ? address : mon_a_r;
    ready_s     = !((state_s == S_DRD) || (state_s == S_DCAP) || (state_s == S_DWR)) && !pend_v_s;
  end

  // Debug registers, pending slot, error flag and CPU read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_v_r    <= 1'b0;
      pend_kind_r <= K_A;
      pend_jdo_r  <= 38'd0;
      wr_data_r   <= 32'd0;
      mon_a_r     <= {ADDR_W{1'b0}};
      mon_d_r     <= 32'd0;
      readdata_r  <= 32'd0;
      rd_done_r   <= 1'b0;
      ready_r     <= 1'b1;
      error_r     <= 1'b0;
    end else begin
      pend_v_r    <= pend_v_s;
      pend_kind_r <= pend_kind_s;
      pend_jdo_r  <= pend_jdo_s;
      rd_done_r   <= (state_r == S_CRD);
      ready_r     <= ready_s;
      if (err_set_s)      error_r <= 1'b1;
      else if (err_clr_s) error_r <= 1'b0;
      else                error_r <= error_r;
      if (exec_v_s && (exec_kind_s == K_A))                mon_a_r <= exec_jdo_s[17 +: ADDR_W];
      else if ((state_r == S_DWR) || (state_r == S_DCAP))  mon_a_r <= mon_a_r + ADDR_ONE;
      else                                                 mon_a_r <= mon_a_r;
      if (exec_v_s && (exec_kind_s == K_B)) wr_data_r <= exec_jdo_s[34:3];
      else                                  wr_data_r <= wr_data_r;
      if (state_r == S_DWR)       mon_d_r <= wr_data_r;
      else if (state_r == S_DCAP) mon_d_r <= ram_q_r;
      else                        mon_d_r <= mon_d_r;
      if (state_r == S_CRD) readdata_r <= ram_q_r;
      else                  readdata_r <= readdata_r;
    end
  end

  // Monitor RAM: byte-lane write port and one registered read port; contents not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_be_s[i]) mem[mem_waddr_s][8*i +: 8] <= mem_wdata_s[8*i +: 8];
      end
    end
    ram_q_r <= mem[mem_raddr_s];
  end

endmodule

// File: tb/tb_hello_world_nios2e_cpu_debug_monmem.sv
// Self-checking bench for the debug monitor memory controller.
// It keeps a word-level model of the RAM and the debug registers and
// checks the DUT against it on randomised data.
module tb_hello_world_nios2e_cpu_debug_monmem;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
  logic [7:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata, MonDReg;
  logic        waitrequest, monitor_ready, monitor_error;
  logic [7:0]  MonAReg;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_mem [256];
  logic [7:0]  m_a;

  always #5 clk = ~clk;

  hello_world_nios2e_cpu_debug_monmem #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a), .take_action_ocimem_b(take_action_ocimem_b),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata), .waitrequest(waitrequest),
    .MonAReg(MonAReg), .MonDReg(MonDReg), .monitor_ready(monitor_ready),
    .monitor_error(monitor_error)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // mask bit0 = ocimem_a, bit1 = ocimem_b, bit2 = no_action_ocimem_a; held for one cycle
  task automatic pulse(input logic [2:0] mask, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a = mask[0]; take_action_ocimem_b = mask[1]; take_no_action_ocimem_a = mask[2];
    tick();
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
  endtask

  function automatic logic [37:0] j_a(input logic [7:0] addr, input logic rd, input logic clr);
    logic [37:0] j;
    j = {$urandom, $urandom};
    j[17 +: 8] = addr; j[34] = rd; j[35] = clr;
    return j;
  endfunction

  function automatic logic [37:0] j_b(input logic [31:0] d);
    logic [37:0] j;
    j = {$urandom, $urandom};
    j[34:3] = d;
    return j;
  endfunction

  // CPU read: returns the number of stalled cycles and the data seen when waitrequest drops
  task automatic cpu_read(input logic [7:0] a, output int cnt, output logic [31:0] d);
    read = 1'b1; address = a; #1;
    cnt = 0;
    while (waitrequest && cnt < 20) begin tick(); cnt++; end
    d = readdata;
    read = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; jdo = 38'd0; read = 1'b0; write = 1'b0; address = 8'd0;
    writedata = 32'd0; byteenable = 4'd0;
    take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
    tick(); tick();
    reset_n = 1'b1; tick();
    m_a = 8'd0;
    n_tests++; if (MonAReg !== 8'h00) begin n_fail++; $display("FAIL reset_MonAReg got %h want 00", MonAReg); end
    n_tests++; if (MonDReg !== 32'd0) begin n_fail++; $display("FAIL reset_MonDReg got %h want 0", MonDReg); end
    n_tests++; if (readdata !== 32'd0) begin n_fail++; $display("FAIL reset_readdata got %h want 0", readdata); end
    n_tests++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b0 || waitrequest !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags got rdy=%b err=%b wait=%b want 1 0 0", monitor_ready, monitor_error, waitrequest); end
  endtask

  task automatic test_fill();
    logic [31:0] d;
    pulse(3'b001, j_a(8'h00, 1'b0, 1'b0));
    m_a = 8'h00;
    n_tests++; if (MonAReg !== 8'h00 || monitor_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_addr got a=%h rdy=%b want 00 1", MonAReg, monitor_ready); end
    for (int i = 0; i < 256; i++) begin
      d = $urandom;
      pulse(3'b010, j_b(d));
      n_tests++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL fill_busy got %b want 0", monitor_ready); end
      tick();
      model_mem[m_a] = d; m_a = m_a + 8'd1;
      n_tests++; if (MonAReg !== m_a || MonDReg !== d || monitor_ready !== 1'b1) begin
        n_fail++; $display("FAIL fill_word got a=%h d=%h rdy=%b want %h %h 1", MonAReg, MonDReg, monitor_ready, m_a, d); end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] a;
    pulse(3'b001, j_a(8'h10, 1'b0, 1'b0));
    pulse(3'b010, j_b(32'hDEADBEEF));
    n_tests++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL wr_busy got %b want 0", monitor_ready); end
    tick();
    model_mem[8'h10] = 32'hDEADBEEF;
    n_tests++; if (MonAReg !== 8'h11 || monitor_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_done got a=%h rdy=%b want 11 1", MonAReg, monitor_ready); end
    pulse(3'b001, j_a(8'h10, 1'b1, 1'b0));
    n_tests++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL rd_n1 got %b want 0", monitor_ready); end
    tick();
    n_tests++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL rd_n2 got %b want 0", monitor_ready); end
    tick();
    n_tests++; if (monitor_ready !== 1'b1 || MonDReg !== 32'hDEADBEEF || MonAReg !== 8'h11) begin
      n_fail++; $display("FAIL rd_n3 got rdy=%b d=%h a=%h want 1 deadbeef 11", monitor_ready, MonDReg, MonAReg); end
    pulse(3'b100, 38'd0); tick(); tick();
    n_tests++; if (MonDReg !== model_mem[8'h11] || MonAReg !== 8'h12) begin
      n_fail++; $display("FAIL rd_next got d=%h a=%h want %h 12", MonDReg, MonAReg, model_mem[8'h11]); end
    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom_range(0, 255));
      pulse(3'b001, j_a(a, 1'b1, 1'b0)); tick(); tick();
      n_tests++; if (MonDReg !== model_mem[a] || MonAReg !== a + 8'd1) begin
        n_fail++; $display("FAIL rd_rand got d=%h a=%h want %h %h", MonDReg, MonAReg, model_mem[a], a + 8'd1); end
      pulse(3'b100, 38'd0); tick(); tick();
      n_tests++; if (MonDReg !== model_mem[a + 8'd1] || MonAReg !== a + 8'd2) begin
        n_fail++; $display("FAIL rd_rand_next got d=%h a=%h want %h %h", MonDReg, MonAReg, model_mem[a + 8'd1], a + 8'd2); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    d = $urandom;
    pulse(3'b001, j_a(8'hFF, 1'b0, 1'b0));
    pulse(3'b010, j_b(d)); tick();
    model_mem[8'hFF] = d;
    n_tests++; if (MonAReg !== 8'h00 || MonDReg !== d) begin
      n_fail++; $display("FAIL wrap_wr got a=%h d=%h want 00 %h", MonAReg, MonDReg, d); end
    pulse(3'b001, j_a(8'hFF, 1'b1, 1'b0)); tick(); tick();
    n_tests++; if (MonDReg !== d || MonAReg !== 8'h00) begin
      n_fail++; $display("FAIL wrap_rd got d=%h a=%h want %h 00", MonDReg, MonAReg, d); end
  endtask

  task automatic test_overrun();
    logic [7:0]  x, q;
    logic [31:0] d2;
    x = 8'($urandom_range(0, 255)); d2 = $urandom;
    pulse(3'b001, j_a(x, 1'b1, 1'b0));   // accepted, read starts
    pulse(3'b010, j_b(d2));              // busy: goes to the pending slot
    pulse(3'b100, 38'd0);                // slot full: dropped
    n_tests++; if (monitor_ready !== 1'b0 || monitor_error !== 1'b1 || MonDReg !== model_mem[x] || MonAReg !== x + 8'd1) begin
      n_fail++; $display("FAIL ovr_n3 got rdy=%b err=%b d=%h a=%h want 0 1 %h %h", monitor_ready, monitor_error, MonDReg, MonAReg, model_mem[x], x + 8'd1); end
    tick();
    n_tests++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL ovr_n4 got %b want 0", monitor_ready); end
    tick();
    model_mem[x + 8'd1] = d2;
    n_tests++; if (monitor_ready !== 1'b1 || MonDReg !== d2 || MonAReg !== x + 8'd2) begin
      n_fail++; $display("FAIL ovr_pend got rdy=%b d=%h a=%h want 1 %h %h", monitor_ready, MonDReg, MonAReg, d2, x + 8'd2); end
    pulse(3'b001, j_a(8'h00, 1'b0, 1'b1));
    n_tests++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %b want 0", monitor_error); end
    q = 8'($urandom_range(0, 255));
    pulse(3'b011, j_a(q, 1'b0, 1'b0));   // a and b together: b is dropped
    n_tests++; if (MonAReg !== q || monitor_error !== 1'b1 || monitor_ready !== 1'b1) begin
      n_fail++; $display("FAIL simul got a=%h err=%b rdy=%b want %h 1 1", MonAReg, monitor_error, monitor_ready, q); end
    pulse(3'b001, j_a(q, 1'b1, 1'b1)); tick(); tick();
    n_tests++; if (MonDReg !== model_mem[q] || monitor_error !== 1'b0) begin
      n_fail++; $display("FAIL simul_nowrite got d=%h err=%b want %h 0", MonDReg, monitor_error, model_mem[q]); end
  endtask

  task automatic test_cpu_collision();
    logic [7:0]  t;
    logic [31:0] d, got;
    int          cnt;
    for (int k = 0; k < 2; k++) begin
      t = (k == 0) ? 8'h20 : 8'h21;
      d = $urandom;
      pulse(3'b001, j_a(t, 1'b0, 1'b0));
      jdo = j_b(d); take_action_ocimem_b = 1'b1; read = 1'b1; address = 8'h20; #1;
      n_tests++; if (waitrequest !== 1'b1) begin n_fail++; $display("FAIL coll_wait got %b want 1", waitrequest); end
      tick(); take_action_ocimem_b = 1'b0;
      model_mem[t] = d;
      cnt = 1;
      while (waitrequest && cnt < 20) begin tick(); cnt++; end
      got = readdata; read = 1'b0; tick();
      n_tests++; if (cnt >= 20 || cnt < 2) begin n_fail++; $display("FAIL coll_stall got %0d cycles want 2..19", cnt); end
      n_tests++; if (got !== model_mem[8'h20] || MonDReg !== d) begin
        n_fail++; $display("FAIL coll_data got rd=%h d=%h want %h %h", got, MonDReg, model_mem[8'h20], d); end
    end
  endtask

  task automatic test_cpu_rw();
    logic [7:0]  a;
    logic [31:0] d, got;
    logic [3:0]  be;
    int          cnt;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom_range(0, 255)); d = $urandom; be = 4'($urandom_range(0, 15));
      write = 1'b1; address = a; writedata = d; byteenable = be; #1;
      n_tests++; if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_wait got %b want 0", waitrequest); end
      tick(); write = 1'b0;
      for (int b = 0; b < 4; b++) if (be[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
      cpu_read(a, cnt, got);
      n_tests++; if (cnt >= 20 || got !== model_mem[a]) begin
        n_fail++; $display("FAIL cpu_rd got %h after %0d cycles want %h", got, cnt, model_mem[a]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, got;
    int          cnt;
    pulse(3'b001, j_a(8'h30, 1'b1, 1'b0));   // now in the read's address cycle
    reset_n = 1'b0; #1;
    n_tests++; if (MonDReg !== 32'd0 || monitor_ready !== 1'b1 || MonAReg !== 8'h00 || readdata !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid got d=%h rdy=%b a=%h rd=%h want 0 1 00 0", MonDReg, monitor_ready, MonAReg, readdata); end
    tick(); reset_n = 1'b1; tick();
    d = ~model_mem[8'h40];
    pulse(3'b001, j_a(8'h40, 1'b0, 1'b0));
    pulse(3'b010, j_b(d));                   // now in the write cycle
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    pulse(3'b001, j_a(8'h40, 1'b1, 1'b0)); tick(); tick();
    n_tests++; if (MonDReg !== model_mem[8'h40]) begin
      n_fail++; $display("FAIL rst_dwr got %h want %h", MonDReg, model_mem[8'h40]); end
    d = $urandom;
    write = 1'b1; address = 8'h30; writedata = d; byteenable = 4'b0011; tick(); write = 1'b0;
    model_mem[8'h30][15:0] = d[15:0];
    cpu_read(8'h30, cnt, got);
    n_tests++; if (cnt >= 20 || got !== model_mem[8'h30]) begin
      n_fail++; $display("FAIL rst_be got %h want %h", got, model_mem[8'h30]); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_wrap();
    test_overrun();
    test_cpu_collision();
    test_cpu_rw();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
